// File: rtl/simd_fifo_buffer.sv
// simd_fifo_buffer: DEPTH x WIDTH first-word-fall-through FIFO with occupancy,
// almost-full and synchronous flush. Handshakes: push/ready on the write side,
// valid/pop on the read side. All status outputs decode from registered state.
module simd_fifo_buffer #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned AF_THRESH = DEPTH - 1,
  localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  output logic             ready,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid,
  input  logic             pop,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count,
  output logic             almost_full
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PtrLast = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CntFull = CW'(DEPTH);
  localparam logic [CW-1:0] CntAf   = CW'(AF_THRESH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wp;
  logic [PW-1:0]    r_rp;
  logic [CW-1:0]    r_cnt;

  logic             w_push_acc;
  logic             w_pop_acc;
  logic [PW-1:0]    w_wp_next;
  logic [PW-1:0]    w_rp_next;
  logic [CW-1:0]    w_cnt_d;

  // Status decode and handshake qualification, from registered count only
  always_comb begin
    ready       = (r_cnt != CntFull);
    valid       = (r_cnt != '0);
    almost_full = (r_cnt >= CntAf);
    count       = r_cnt;
    data_o      = r_mem[r_rp];
    w_push_acc  = push & ready;
    w_pop_acc   = pop & valid;
  end

  // Pointer increment with explicit wrap so non-power-of-two depths work
  always_comb begin
    w_wp_next = (r_wp == PtrLast) ? '0 : r_wp + 1'b1;
    w_rp_next = (r_rp == PtrLast) ? '0 : r_rp + 1'b1;
  end

  // Occupancy next-state: push-only +1, pop-only -1, otherwise hold
  always_comb begin
    w_cnt_d = r_cnt;
    if (w_push_acc && !w_pop_acc) begin
      w_cnt_d = r_cnt + 1'b1;
    end else if (!w_push_acc && w_pop_acc) begin
      w_cnt_d = r_cnt - 1'b1;
    end
  end

  // Pointer and counter state; flush overrides any handshake in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push_acc) r_wp <= w_wp_next;
      if (w_pop_acc)  r_rp <= w_rp_next;
      r_cnt <= w_cnt_d;
    end
  end

  // Storage array: not reset, written only on an accepted non-flushed push
  always_ff @(posedge clk) begin
    if (w_push_acc && !flush) begin
      r_mem[r_wp] <= data_i;
    end
  end

endmodule
